// File: rtl/mem_bist_master_pkg.sv
// Shared types and constants for the memory BIST master: state encoding,
// default geometry/timeout, and the write/compare data pattern.
package mem_bist_master_pkg;

  localparam int AW_DEF  = 10;
  localparam int DW_DEF  = 32;
  localparam int TMO_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT,
    FIN
  } bist_state_t;

  function automatic logic [DW_DEF-1:0] bist_pattern(input logic [DW_DEF-1:0] seed,
                                                     input logic [DW_DEF-1:0] off);
    return seed + off;
  endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-data checker: one compare per completed read, saturating error count,
// first-failing address latched; results update on the edge that accepts ready.
module mem_bist_cmp
  import mem_bist_master_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] rdata,
  input  logic [DW-1:0] exp_dat,
  input  logic [AW-1:0] addr,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] first_err_addr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (clr) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (en && (rdata != exp_dat)) begin
      if (err_count != '1)
        err_count <= err_count + (AW+1)'(1);
      // A saturated count never returns to zero, so zero means "no mismatch yet".
      if (err_count == '0)
        first_err_addr <= addr;
    end
  end

endmodule

// File: rtl/mem_bist_master.sv
// March-style BIST: write seed+i to len words, read back and compare. Each
// access is one request cycle plus a wait for ready, bounded by TMO cycles.
module mem_bist_master
  import mem_bist_master_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] seed,
  output logic          valid,
  output logic          wr_rd,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata,
  input  logic          ready,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] first_err_addr
);

  localparam int TW = $clog2(TMO + 1);

  bist_state_t   state;
  logic [AW-1:0] base_r;
  logic [AW:0]   len_r;
  logic [AW:0]   off;
  logic [DW-1:0] seed_r;
  logic [TW-1:0] wcnt;
  logic          res_vld;

  logic          last;
  logic          tmo_hit;
  logic [AW:0]   off_nx;
  logic [AW-1:0] addr_nx;
  logic [DW-1:0] exp_dat;
  logic          cmp_en;
  logic          accept;

  assign last    = (off == len_r - (AW+1)'(1));
  assign off_nx  = off + (AW+1)'(1);
  assign addr_nx = base_r + off_nx[AW-1:0];
  assign tmo_hit = (wcnt == TW'(TMO - 1));
  assign exp_dat = bist_pattern(seed_r, DW'(off));
  assign cmp_en  = (state == RD_WAIT) && ready;
  assign accept  = (state == IDLE) && start;
  assign pass    = res_vld && (err_count == '0) && !timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      valid   <= 1'b0;
      wr_rd   <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      res_vld <= 1'b0;
      base_r  <= '0;
      len_r   <= '0;
      seed_r  <= '0;
      off     <= '0;
      wcnt    <= '0;
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      wdata <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            base_r  <= base_addr;
            // len==0 encodes a full sweep of the address space.
            len_r   <= (len == '0) ? {1'b1, {AW{1'b0}}} : len;
            seed_r  <= seed;
            off     <= '0;
            timeout <= 1'b0;
            res_vld <= 1'b0;
            busy    <= 1'b1;
            wr_rd   <= 1'b1;
            valid   <= 1'b1;
            addr    <= base_addr;
            wdata   <= bist_pattern(seed, '0);
            state   <= WR_REQ;
          end
        end
        WR_REQ: begin
          wcnt  <= '0;
          state <= WR_WAIT;
        end
        WR_WAIT: begin
          if (ready) begin
            valid <= 1'b1;
            if (last) begin
              off   <= '0;
              wr_rd <= 1'b0;
              addr  <= base_r;
              state <= RD_REQ;
            end else begin
              off   <= off_nx;
              addr  <= addr_nx;
              wdata <= bist_pattern(seed_r, DW'(off_nx));
              state <= WR_REQ;
            end
          end else if (tmo_hit) begin
            timeout <= 1'b1;
            wr_rd   <= 1'b0;
            done    <= 1'b1;
            res_vld <= 1'b1;
            state   <= FIN;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        RD_REQ: begin
          wcnt  <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (ready) begin
            if (last) begin
              done    <= 1'b1;
              res_vld <= 1'b1;
              state   <= FIN;
            end else begin
              valid <= 1'b1;
              off   <= off_nx;
              addr  <= addr_nx;
              state <= RD_REQ;
            end
          end else if (tmo_hit) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            res_vld <= 1'b1;
            state   <= FIN;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_bist_cmp #(
    .AW(AW),
    .DW(DW)
  ) u_cmp (
    .clk           (clk),
    .rst           (rst),
    .clr           (accept),
    .en            (cmp_en),
    .rdata         (rdata),
    .exp_dat       (exp_dat),
    .addr          (addr),
    .err_count     (err_count),
    .first_err_addr(first_err_addr)
  );

endmodule

// File: tb/tb_mem_bist_master.sv
// Bench for mem_bist_master: behavioural memory with programmable latency,
// stuck-ready and write corruption, plus a per-run timeline model.
module tb_mem_bist_master;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int TMO  = 16;
  localparam int MAXC = 4400;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] seed = '0;
  logic [DW-1:0] rdata = '0;
  logic          ready = 1'b0;
  logic          valid, wr_rd, busy, done, pass, timeout;
  logic [AW-1:0] addr, first_err_addr;
  logic [DW-1:0] wdata;
  logic [AW:0]   err_count;

  always #5 clk = ~clk;

  mem_bist_master #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .seed(seed), .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: ready arrives lat cycles after the request strobe.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit            corrupt [0:(1<<AW)-1];
  int            pend = 0, lat = 1, acc_total = 0, acc_base = 0, stall_k = -1;
  logic          p_wr;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_dat;

  always @(negedge clk) begin
    ready = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        ready = 1'b1;
        if (p_wr) mem[p_addr] = p_dat ^ {{(DW-1){1'b0}}, corrupt[p_addr]};
        else      rdata = mem[p_addr];
      end
    end
    if (valid) begin
      if (acc_total - acc_base != stall_k) begin
        pend   = lat;
        p_wr   = wr_rd;
        p_addr = addr;
        p_dat  = wdata;
      end
      acc_total++;
    end
  end

  // Expected timeline, indexed by cycles since the start pulse.
  bit            ev [0:MAXC];
  bit            ew [0:MAXC];
  logic [AW-1:0] ea [0:MAXC];
  logic [DW-1:0] ed [0:MAXC];
  int            done_rel;
  bit            exp_to;
  int            exp_errs;
  logic [AW-1:0] exp_first;

  task automatic build_model(input logic [AW-1:0] b, input logic [AW:0] l,
                             input logic [DW-1:0] s, input int L, input int k);
    int n, issued, r, off;
    logic [AW-1:0] a;
    n = (l == 0) ? (1 << AW) : int'(l);
    for (int i = 0; i <= MAXC; i++) begin
      ev[i] = 0; ew[i] = 0; ea[i] = '0; ed[i] = '0;
    end
    exp_to    = (k >= 0) && (k < 2*n);
    issued    = exp_to ? k + 1 : 2*n;
    exp_errs  = 0;
    exp_first = '0;
    for (int j = 0; j < issued; j++) begin
      r   = 1 + j*(1+L);
      off = (j < n) ? j : j - n;
      a   = AW'((int'(b) + off) % (1 << AW));
      ev[r] = 1;
      ew[r] = (j < n);
      ea[r] = a;
      ed[r] = (j < n) ? s + DW'(off) : '0;
      if (j >= n && !(exp_to && j == k) && corrupt[a]) begin
        if (exp_errs == 0) exp_first = a;
        exp_errs++;
      end
    end
    done_rel = exp_to ? 1 + k*(1+L) + 1 + TMO : 2*n*(1+L) + 1;
  endtask

  bit            checking = 0;
  int            start_cyc = 0;
  int            crel;
  int            dut_done_rel;
  logic [AW-1:0] addr_log [$];

  always @(negedge clk) begin
    if (checking) begin
      crel = cyc - start_cyc;
      if (crel >= 1 && crel <= done_rel + 2) begin
        chk("valid", valid, ev[crel]);
        chk("busy", busy, crel <= done_rel);
        chk("done", done, crel == done_rel);
        chk("wdata", wdata, ed[crel]);
        if (ev[crel]) begin
          chk("wr_rd", wr_rd, ew[crel]);
          chk("addr", addr, ea[crel]);
        end else if (crel > done_rel) begin
          chk("wr_rd_idle", wr_rd, 1'b0);
        end
        if (valid) addr_log.push_back(addr);
        if (done) dut_done_rel = crel;
        if (crel >= done_rel) begin
          chk("pass", pass, (exp_errs == 0) && !exp_to);
          chk("timeout", timeout, exp_to);
          chk("err_count", err_count, exp_errs);
          chk("first_err_addr", first_err_addr, exp_first);
        end
      end
    end
  end

  // extra_start: cycle to re-pulse start (-2 = the done cycle); abort_rel: cycle to assert reset.
  task automatic run(input logic [AW-1:0] b, input logic [AW:0] l, input logic [DW-1:0] s,
                     input int L, input int k, input int extra_start, input int abort_rel);
    int ex;
    build_model(b, l, s, L, k);
    ex = (extra_start == -2) ? done_rel : extra_start;
    lat = L;
    stall_k = k;
    @(posedge clk); #1;
    base_addr = b; len = l; seed = s; start = 1'b1;
    start_cyc = cyc;
    acc_base = acc_total;
    addr_log.delete();
    dut_done_rel = -1;
    checking = 1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom); len = (AW+1)'($urandom); seed = $urandom;
    while ((cyc - start_cyc) < done_rel + 3) begin
      if ((cyc - start_cyc) == ex) start = 1'b1;
      if ((cyc - start_cyc) == abort_rel) begin
        chk("v5_in_read_wait", {busy, valid, wr_rd}, 3'b100);
        chk("v5_err_before_rst", err_count, 1);
        checking = 0;
        #2 rst = 1'b0;
        #1;
        chk("rst_ctrl", {valid, wr_rd, busy, done, pass, timeout}, 6'b0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err", first_err_addr, 0);
        repeat (3) begin
          @(negedge clk);
          chk("v5_no_done_in_rst", {done, busy}, 2'b00);
        end
        rst = 1'b1;
        repeat (4) begin
          @(negedge clk);
          chk("v5_no_done_after", {done, busy}, 2'b00);
        end
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    checking = 0;
  endtask

  task automatic clear_corrupt();
    for (int i = 0; i < (1 << AW); i++) corrupt[i] = 0;
  endtask

  logic [AW-1:0] v2a [4];

  initial begin
    int rl, rk, rL;
    logic [AW-1:0] rb;
    clear_corrupt();
    v2a[0] = 10'h3FE; v2a[1] = 10'h3FF; v2a[2] = 10'h000; v2a[3] = 10'h001;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {valid, wr_rd, busy, done, pass, timeout}, 6'b0);
    chk("reset_addr", addr, 0);
    chk("reset_wdata", wdata, 0);
    chk("reset_err", {err_count, first_err_addr}, 0);
    @(negedge clk) rst = 1'b1;

    // V1 clean run
    run(10'h3F0, 4, 32'h1000_0000, 1, -1, -1, -1);
    chk("v1_done_cycle", dut_done_rel, 17);
    chk("v1_mem_3f0", mem[10'h3F0], 32'h1000_0000);
    chk("v1_mem_3f3", mem[10'h3F3], 32'h1000_0003);
    chk("v1_pass", pass, 1);

    // V2 address wrap, start pulsed in FIN must be ignored
    run(10'h3FE, 4, 32'hCAFE_0000, 1, -1, -2, -1);
    chk("v2_log_len", addr_log.size(), 8);
    for (int i = 0; i < 8; i++) chk("v2_addr_seq", addr_log[i], v2a[i % 4]);

    // V3 corrupted word
    corrupt[5] = 1;
    run(10'h000, 8, 32'h0, 1, -1, -1, -1);
    chk("v3_err_count", err_count, 1);
    chk("v3_first_err", first_err_addr, 10'h005);
    chk("v3_pass", pass, 0);
    clear_corrupt();

    // V4 memory goes silent on the 4th write
    run(10'h100, 8, 32'h55AA_0000, 1, 3, -1, -1);
    chk("v4_timeout", timeout, 1);
    chk("v4_done_cycle", dut_done_rel, 24);
    chk("v4_no_reads", addr_log.size(), 4);
    chk("v4_pass", pass, 0);

    // V5 reset during a read wait, then a clean run
    corrupt[10'h050] = 1;
    run(10'h050, 6, 32'h1234_5678, 1, -1, -1, 18);
    clear_corrupt();
    repeat (3) @(posedge clk);
    run(10'h050, 6, 32'h8765_4321, 1, -1, -1, -1);
    chk("v5_rerun_pass", pass, 1);

    // V6 full sweep with a stray start mid-run
    run(10'h2A5, 0, 32'hDEAD_BEEF, 1, -1, 100, -1);
    chk("v6_done_cycle", dut_done_rel, 4097);

    // Randomised runs: latency, length, stuck memory and corruption all vary
    for (int t = 0; t < 10; t++) begin
      rl = $urandom_range(1, 40);
      rL = $urandom_range(1, 3);
      rb = AW'($urandom);
      rk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2*rl - 1) : -1;
      clear_corrupt();
      if ($urandom_range(0, 1) == 1) corrupt[AW'(int'(rb) + $urandom_range(0, rl - 1))] = 1;
      if ($urandom_range(0, 2) == 0) corrupt[AW'(int'(rb) + $urandom_range(0, rl - 1))] = 1;
      run(rb, (AW+1)'(rl), $urandom, rL, rk, (t % 3 == 0) ? 5 : -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_bist_master.md
MEM_BIST_MASTER -- requirements
Module: mem_bist_master

Interface
REQ-001 Parameters SHALL be: AW, 10, address width; DW, 32, data width; TMO, 16, max cycles waiting for ready per access.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle request to begin a test run; ignored while busy.
REQ-006 base_addr  input  AW  first memory address of the run.
REQ-007 len  input  AW+1  number of words, 1..2**AW; value 0 SHALL be treated as 2**AW.
REQ-008 seed  input  DW  pattern seed.
REQ-009 valid  output  1  memory request strobe.
REQ-010 wr_rd  output  1  1 = write, 0 = read; meaningful only with valid.
REQ-011 addr  output  AW  memory address.
REQ-012 wdata  output  DW  write data.
REQ-013 rdata  input  DW  read data from memory, sampled only when ready=1 during a read.
REQ-014 ready  input  1  memory completion indication.
REQ-015 busy  output  1  high from the cycle after start is accepted until done.
REQ-016 done  output  1  one-cycle pulse at the end of a run.
REQ-017 pass  output  1  valid from done until next start: 1 = no mismatch and no timeout.
REQ-018 timeout  output  1  sticky per run: an access exceeded TMO cycles.
REQ-019 err_count  output  AW+1  number of read mismatches, saturating at all-ones.
REQ-020 first_err_addr  output  AW  address of the first mismatch; 0 if none.

Function
REQ-021 The FSM SHALL have states IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FIN.
- IDLE -> WR_REQ on start.
- WR_REQ -> WR_WAIT after 1 cycle.
- WR_WAIT -> WR_REQ on ready with words remaining; -> RD_REQ on ready after the last word.
- RD_REQ -> RD_WAIT after 1 cycle.
- RD_WAIT -> RD_REQ on ready with words remaining; -> FIN on ready after the last word.
- FIN -> IDLE after 1 cycle.
REQ-022 valid SHALL be high for exactly one cycle per access: the REQ-state cycle only.
REQ-023 In each REQ state, addr SHALL be (base_addr + offset) mod 2**AW, wrapping past 2**AW-1 to 0.
REQ-024 Pattern data for word offset i SHALL be seed + i, mod 2**DW; wdata SHALL carry it in WR_REQ and hold 0 otherwise.
REQ-025 In WR_*, wr_rd SHALL be 1; in RD_*, 0; in IDLE and FIN, 0.
REQ-026 On ready in RD_WAIT, rdata SHALL be compared with the pattern for the same offset.
- On mismatch, err_count increments (saturating).
- On the first mismatch, first_err_addr latches addr.
REQ-027 ready SHALL be ignored in IDLE, WR_REQ, RD_REQ and FIN.
REQ-028 A per-access wait counter SHALL clear on each REQ state.
- If TMO cycles elapse in a WAIT state without ready, timeout is set and the FSM goes directly to FIN, skipping remaining accesses.
REQ-029 done SHALL assert during FIN; pass = (err_count==0) && !timeout.
REQ-030 On an accepted start, base_addr, len and seed SHALL be registered.
- err_count, first_err_addr, timeout and pass clear in the same edge.
REQ-031 Run latency without timeout SHALL be 2*len*(1+L)+1 cycles from start to done, where L is the memory ready latency; L=1 gives 4*len+1.
REQ-032 start coinciding with FIN SHALL be ignored; start is accepted only in IDLE.

Reset
REQ-033 On rst low, outputs SHALL be cleared asynchronously regardless of state, and the FSM enters IDLE; a run in progress is abandoned without done.
- Cleared to 0: valid, wr_rd, addr, wdata, busy, done, pass, timeout, err_count, first_err_addr.
REQ-034 Release of rst SHALL take effect on the next rising clk edge.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the default AW/DW/TMO constants, and the pattern function (seed + offset).
REQ-036 One sub-module SHALL be natural: mem_bist_cmp, holding the compare, saturating err_count and first_err_addr latch.

Verification
REQ-037 The scenarios are directed at a VLSIGURU-style responding memory (ready one cycle after valid, stores and returns data).
- V1 clean run: base=0x3F0, len=4, seed=0x1000_0000 -> writes 0x1000_0000..0x1000_0003 at 0x3F0..0x3F3; done at cycle 17; pass=1; err_count=0.
- V2 wrap: base=0x3FE, len=4 -> addr sequence 0x3FE, 0x3FF, 0x000, 0x001 in both phases; pass=1.
- V3 corruption: memory flips bit 0 of the word at 0x005; base=0, len=8, seed=0 -> err_count=1, first_err_addr=0x005, pass=0.
- V4 timeout: memory never raises ready after the 3rd write, TMO=16 -> timeout=1, done exactly 16 cycles after the wait begins, no reads issued, pass=0.
- V5 reset mid-run: rst low during RD_WAIT -> all outputs 0 immediately, no done pulse; a new start then yields a clean pass.
- V6 start while busy: start pulsed mid-run is ignored; len=0 runs 1024 words, done at cycle 4097.
